ifetch_buffer: RTL
==================

Name: ifetch_buffer

Overview:
- Instruction-fetch line buffer between the processor fetch stage and the instruction ROM (mem_64k, read-only use).
- Converts 16-bit instruction fetches into 64-bit (4-word) block reads over the memory startReq/reqFinish handshake.
- Holds the most recently filled block so sequential fetches hit without a memory access.

Parameters:
- MISS_CNT_W, 16, width of the saturating miss counter.

Ports:
- clk  input  1  system clock.
- rstn  input  1  reset; asynchronous, active-low.
- fetchEn  input  1  processor requests the instruction at fetchAddr this cycle.
- fetchAddr  input  16  word address of the requested instruction.
- instr  output  16  instruction word; valid only while instrValid=1.
- instrValid  output  1  fetch satisfied this cycle; processor stalls while fetchEn=1 and instrValid=0.
- startReqI  output  1  one-cycle pulse starting a ROM block read.
- inAddrI  output  16  block address, always {addr[15:2],2'b00}; held stable from startReqI until reqFinishI.
- outDataI  input  64  ROM block data; word k occupies bits [16k+15:16k].
- reqFinishI  input  1  one-cycle pulse; outDataI valid in the same cycle.
- missCount  output  MISS_CNT_W  demand misses since reset; saturates at all-ones.

Behaviour:
- Reset (rstn low, asynchronous):
  - Clear all buffer valid bits and tags.
  - State=IDLE; startReqI=0, inAddrI=0, instr=0, instrValid=0, missCount=0.
  - A ROM response arriving after reset is ignored because state=IDLE.
- Hit: lineValid and lineTag==fetchAddr[15:2] and state!=FILL.
  - instrValid and instr are combinational in the same cycle: instr = word fetchAddr[1:0] of the line.
  - When fetchEn=0: instrValid=0, instr=0.
- FSM states and transitions:
  - IDLE, fetchEn=1 and miss: missCount+1 (saturating), assert startReqI for this cycle, latch inAddrI, go to FILL.
  - FILL: startReqI=0, instrValid=0.
  - FILL, reqFinishI=1: write outDataI into the line, set tag from inAddrI[15:2], set lineValid, go to IDLE.
  - The hit is re-evaluated the next cycle, so the minimum miss penalty is the ROM latency plus 1 cycle.
- fetchAddr changes during FILL (e.g. a branch):
  - The fill still completes and is installed.
  - If the new address misses, a new request is issued from IDLE.
  - Outstanding requests are never aborted; at most one is outstanding.
- Block address wraps: 0xFFFC is the last block.
- A reqFinishI seen in IDLE is ignored.
- The buffer never writes memory; the isRd side is tied off at the SoC level.

Optional Feature:
- Macro: IFETCH_PREFETCH_EN.
- Defined: adds a prefetch line (pfValid, pfTag, pfData) and state PFILL.
  - After any demand fill of block B, if the next cycle is not a miss, issue a request for B+4 (0xFFFC wraps to 0x0000) and enter PFILL.
  - The response fills the prefetch line.
  - Demand miss that matches the prefetch line: copy it into the main line in 1 cycle, with no ROM request, and count the miss. The hit is served the next cycle.
  - Demand miss during PFILL:
    - Wait for reqFinishI and install the response into the prefetch line.
    - Then resolve the miss via a prefetch match, or else a demand request.
  - Prefetch requests never increment missCount.
- Undefined: single line only; behaviour exactly as above, and state PFILL does not exist.

Decomposition:
- Shared package ifetch_pkg holds:
  - state enum (IDLE, FILL, PFILL);
  - constants LINE_WORDS=4 and LINE_W=64;
  - function blockAddr(addr) returning {addr[15:2],2'b00}.
- One sub-module: ifetch_line, a tag/valid/data register with fill and lookup ports. Instantiated once, or twice when IFETCH_PREFETCH_EN is defined.

Test Plan:
- Reset then fetchEn=1, fetchAddr=0x0000 with ROM block 0 = 0x4444_3333_2222_1111:
  - one startReqI with inAddrI=0x0000;
  - after reqFinishI, instr=0x1111 with instrValid=1;
  - missCount=1.
- Sequential fetch of 0x0001..0x0003: instr 0x2222, 0x3333, 0x4444, each with same-cycle instrValid and no startReqI.
- Fetch 0x0005 then 0x0004:
  - one request with inAddrI=0x0004;
  - the second fetch hits;
  - missCount=2.
- Branch during FILL: fetchAddr changes from 0x0010 to 0x0020 mid-fill:
  - block 0x0010 is installed;
  - a second request with inAddrI=0x0020 follows;
  - instrValid stays 0 until it completes.
- Assert rstn low during FILL, then release; a late reqFinishI arrives:
  - response ignored;
  - lineValid=0 and missCount=0;
  - the next fetch issues a fresh request.
- IFETCH_PREFETCH_EN defined:
  - fetch 0xFFFC triggers a prefetch of 0x0000;
  - a following fetch of 0x0000 hits via copy with no second ROM request;
  - missCount=2.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types, line geometry and block-address helper for the instruction-fetch buffer.
// IFETCH_PREFETCH_EN adds the PFILL state used by the prefetch line.
package ifetch_pkg;

  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = 64;
  localparam int WORD_W     = LINE_W / LINE_WORDS;

  typedef enum logic [1:0] {
    IDLE,
`ifdef IFETCH_PREFETCH_EN
    PFILL,
`endif
    FILL
  } state_e;

  function automatic logic [15:0] blockAddr(input logic [15:0] addr);
    return {addr[15:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_line.sv
// One buffered 4-word block: valid/tag cleared on reset, data loaded on fill, tag compare for lookup.
import ifetch_pkg::*;

module ifetch_line (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fill_en,
  input  logic [13:0]       fill_tag,
  input  logic [LINE_W-1:0] fill_data,
  input  logic [13:0]       lookup_tag,
  output logic              hit,
  output logic [LINE_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [13:0]       tag_q, tag_d;
  logic [LINE_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d = 1'b1;
      tag_d   = fill_tag;
      data_d  = fill_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  // Payload is only meaningful behind valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign hit  = valid_q && (tag_q == lookup_tag);
  assign data = data_q;

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction-fetch line buffer: serves 16-bit fetches from a 64-bit block, refilling over startReqI/reqFinishI.
// Define IFETCH_PREFETCH_EN to add a next-block prefetch line (state PFILL).
import ifetch_pkg::*;

module ifetch_buffer #(
  parameter int MISS_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fetchEn,
  input  logic [15:0]           fetchAddr,
  output logic [15:0]           instr,
  output logic                  instrValid,
  output logic                  startReqI,
  output logic [15:0]           inAddrI,
  input  logic [LINE_W-1:0]     outDataI,
  input  logic                  reqFinishI,
  output logic [MISS_CNT_W-1:0] missCount
);

  function automatic logic [MISS_CNT_W-1:0] sat_inc(input logic [MISS_CNT_W-1:0] v);
    return (&v) ? v : v + {{(MISS_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_e                  state_q, state_d;
  logic [15:0]             in_addr_q, in_addr_d;
  logic [MISS_CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic                    start_req;
  logic                    line_fill_en;
  logic [13:0]             line_fill_tag;
  logic [LINE_W-1:0]       line_fill_data;
  logic                    line_hit;
  logic [LINE_W-1:0]       line_data;
  logic                    copy_hit;
  logic [LINE_W-1:0]       copy_data;

  ifetch_line u_line (
    .clk        (clk),
    .rstn       (rstn),
    .fill_en    (line_fill_en),
    .fill_tag   (line_fill_tag),
    .fill_data  (line_fill_data),
    .lookup_tag (fetchAddr[15:2]),
    .hit        (line_hit),
    .data       (line_data)
  );

`ifdef IFETCH_PREFETCH_EN
  logic              pf_fill_en;
  logic              pf_pending_q, pf_pending_d;

  ifetch_line u_pf (
    .clk        (clk),
    .rstn       (rstn),
    .fill_en    (pf_fill_en),
    .fill_tag   (in_addr_q[15:2]),
    .fill_data  (outDataI),
    .lookup_tag (fetchAddr[15:2]),
    .hit        (copy_hit),
    .data       (copy_data)
  );
`else
  assign copy_hit  = 1'b0;
  assign copy_data = '0;
`endif

  always_comb begin
    state_d        = state_q;
    in_addr_d      = in_addr_q;
    miss_cnt_d     = miss_cnt_q;
    start_req      = 1'b0;
    line_fill_en   = 1'b0;
    line_fill_tag  = in_addr_q[15:2];
    line_fill_data = outDataI;
`ifdef IFETCH_PREFETCH_EN
    pf_fill_en     = 1'b0;
    pf_pending_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (fetchEn && !line_hit) begin
          miss_cnt_d = sat_inc(miss_cnt_q);
          if (copy_hit) begin
            // Block already sits in the prefetch line: promote it without touching the ROM.
            line_fill_en   = 1'b1;
            line_fill_tag  = fetchAddr[15:2];
            line_fill_data = copy_data;
          end else begin
            start_req = 1'b1;
            in_addr_d = blockAddr(fetchAddr);
            state_d   = FILL;
          end
        end
`ifdef IFETCH_PREFETCH_EN
        else if (pf_pending_q) begin
          start_req = 1'b1;
          in_addr_d = in_addr_q + 16'd4;
          state_d   = PFILL;
        end
`endif
      end
      FILL: begin
        if (reqFinishI) begin
          line_fill_en = 1'b1;
          state_d      = IDLE;
`ifdef IFETCH_PREFETCH_EN
          pf_pending_d = 1'b1;
`endif
        end
      end
`ifdef IFETCH_PREFETCH_EN
      PFILL: begin
        if (reqFinishI) begin
          pf_fill_en = 1'b1;
          state_d    = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      in_addr_q  <= '0;
      miss_cnt_q <= '0;
`ifdef IFETCH_PREFETCH_EN
      pf_pending_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      in_addr_q  <= in_addr_d;
      miss_cnt_q <= miss_cnt_d;
`ifdef IFETCH_PREFETCH_EN
      pf_pending_q <= pf_pending_d;
`endif
    end
  end

  assign instrValid = fetchEn && line_hit && (state_q != FILL);
  assign instr      = instrValid ? line_data[{fetchAddr[1:0], 4'b0000} +: WORD_W] : '0;
  assign startReqI  = start_req;
  assign inAddrI    = start_req ? in_addr_d : in_addr_q;
  assign missCount  = miss_cnt_q;

endmodule
